mac_seq_ctrl: RTL and testbench
===============================

Name: mac_seq_ctrl

Overview:
- Job sequencer for the 16-bit FloatSD4 MAC pipeline (stages 1-4).
- Accepts a job of N operand beats and issues one beat per cycle into stage 1 via a valid strobe.
- Drives the common inhibit that freezes every stage register when the result consumer back-pressures.
- Counts results leaving stage 4, tags the last result of the job, and pulses done once the pipeline has drained.

Parameters:
CNT_W, 8, width of beat length and issue/retire counters (max job length 2^CNT_W-1)
Q_W, 5, width of the fractional-point configuration word

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  job start pulse; sampled only in IDLE
i_len  input  CNT_W  job length in operand beats; sampled with i_start
i_Q_frac  input  Q_W  job fraction config; sampled with i_start
i_abort  input  1  synchronous job cancel
i_src_valid  input  1  operand buffer has a beat
o_src_ready  output  1  beat consumed this cycle (equals o_pipe_valid)
o_pipe_valid  output  1  valid into MAC stage 1
o_pipe_inhibit  output  1  freeze all MAC stage registers
i_res_valid  input  1  stage-4 o_valid
i_sink_ready  input  1  consumer accepts stage-4 result
o_res_last  output  1  current stage-4 result is the job's last
o_Q_frac  output  Q_W  latched job config, fed to stage 1 i_Q_frac
o_busy  output  1  state != IDLE
o_done  output  1  one-cycle pulse: job fully retired

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; issue_cnt=0, ret_cnt=0, len_r=0, Q_frac_r=0.
  - All outputs 0, o_Q_frac=0.
- States: IDLE, RUN, DRAIN, DONE (registered, 2-bit).
- Inhibit (combinational): o_pipe_inhibit = i_res_valid & ~i_sink_ready. Asserted in any state, including IDLE.
- Issue (combinational):
  - o_pipe_valid = o_src_ready = (state==RUN) & i_src_valid & ~o_pipe_inhibit & (issue_cnt != len_r).
  - issue_cnt increments on each issue.
- Retire:
  - retire = i_res_valid & i_sink_ready & (state==RUN | state==DRAIN).
  - ret_cnt increments on each retire.
  - i_res_valid seen in IDLE/DONE is not counted.
- Last tag (combinational): o_res_last = i_res_valid & (state==RUN | state==DRAIN) & (ret_cnt == len_r-1). It holds while the result is inhibited.
- IDLE:
  - If i_start & i_len!=0: latch len_r=i_len and Q_frac_r=i_Q_frac, clear both counters, go to RUN.
  - i_start with i_len==0 is ignored (stay IDLE, no o_done).
- RUN: the cycle the final beat issues (issue_cnt==len_r-1 with issue) go to DRAIN. Retires proceed concurrently.
- DRAIN: no issue. The cycle the final result retires (ret_cnt==len_r-1 with retire) go to DONE.
- DONE:
  - o_done=1 for exactly one cycle, then IDLE.
  - A new job can start the following cycle.
  - i_start in DONE is ignored.
- i_start while busy: ignored; len_r and Q_frac_r are unchanged.
- i_abort:
  - Any non-IDLE state goes to IDLE next cycle with counters cleared and no o_done.
  - Issue is suppressed in the abort cycle.
  - Results still in flight exit the pipeline uncounted. The integrator either flushes them or discards them via o_busy=0.
  - abort has priority over all other transitions.
- Simultaneous issue and retire in one cycle: both counters update.
- o_Q_frac: holds the latched value through RUN/DRAIN/DONE and stays stable until the next accepted start.
- Latency:
  - Issue to i_res_valid is 4 cycles with no stalls (pipeline property); each inhibit cycle adds 1.
  - Last issue to o_done is 5 cycles with no stalls.
- Counters are CNT_W bits and never wrap; issue_cnt saturates at len_r by the issue guard.

Test Plan:
- Reset mid-RUN (len=10, 3 beats issued) -> all outputs 0 immediately, state IDLE, counters 0; a fresh start with len=2 completes normally.
- Basic job: i_len=4, i_Q_frac=5'd7, src always valid, sink always ready -> o_pipe_valid high 4 consecutive cycles; o_Q_frac=7; o_res_last with the 4th result; o_done 5 cycles after the last issue.
- Back-pressure: len=6, sink_ready low for 3 cycles while result 2 is valid -> o_pipe_inhibit high 3 cycles, no issue during them, result 2 held; all 6 retire once each; o_done once.
- Source starvation: len=3, i_src_valid toggles 1,0,1,0,1 -> issues only on the high cycles; no DRAIN until the 3rd issue; done after 3 retires.
- Edge lengths: i_len=0 -> no busy, no done. i_len=255 -> exactly 255 issues and 255 retires, last tagged on the 255th. Second i_start while busy -> ignored, o_Q_frac unchanged.
- Abort in DRAIN with 2 results outstanding -> IDLE next cycle; no o_done; subsequent i_res_valid not counted and no o_res_last.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the 16-bit FloatSD4 MAC pipeline: issues N operand beats into stage 1,
// drives the shared stage inhibit, counts stage-4 results, tags the last and pulses done.
module mac_seq_ctrl #(
  parameter int CNT_W = 8,
  parameter int Q_W   = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic [Q_W-1:0]   i_Q_frac,
  input  logic             i_abort,
  input  logic             i_src_valid,
  output logic             o_src_ready,
  output logic             o_pipe_valid,
  output logic             o_pipe_inhibit,
  input  logic             i_res_valid,
  input  logic             i_sink_ready,
  output logic             o_res_last,
  output logic [Q_W-1:0]   o_Q_frac,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [Q_W-1:0]   q_frac_q, q_frac_d;

  logic             inhibit;
  logic             active;
  logic             issue;
  logic             retire;
  logic [CNT_W-1:0] len_m1;

  assign len_m1  = len_q - CNT_W'(1);
  assign inhibit = i_res_valid & ~i_sink_ready;
  assign active  = (state_q == RUN) | (state_q == DRAIN);
  // The issue guard on issue_cnt also keeps the counter from ever passing len_q.
  assign issue   = (state_q == RUN) & i_src_valid & ~inhibit & (issue_cnt_q != len_q) & ~i_abort;
  assign retire  = i_res_valid & i_sink_ready & active;

  assign o_pipe_inhibit = inhibit;
  assign o_pipe_valid   = issue;
  assign o_src_ready    = issue;
  assign o_res_last     = i_res_valid & active & (ret_cnt_q == len_m1);
  assign o_Q_frac       = q_frac_q;
  assign o_busy         = (state_q != IDLE);
  assign o_done         = (state_q == DONE);

  always_comb begin
    // NOTE: every _d takes its hold value first, so no branch can leave a latch behind.
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    len_d       = len_q;
    q_frac_d    = q_frac_q;

    if (issue)  issue_cnt_d = issue_cnt_q + CNT_W'(1);
    if (retire) ret_cnt_d   = ret_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (i_start && (i_len != '0) && !i_abort) begin
          len_d       = i_len;
          q_frac_d    = i_Q_frac;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (issue && (issue_cnt_q == len_m1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (retire && (ret_cnt_q == len_m1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything; results still in flight leave the pipe uncounted.
    if (i_abort) begin
      state_d     = IDLE;
      issue_cnt_d = '0;
      ret_cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      len_q       <= '0;
      q_frac_q    <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      len_q       <= len_d;
      q_frac_q    <= q_frac_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a 4-stage valid pipeline stands in for the MAC, and a job-level
// model (beats issued / results retired / done owed) predicts every output each cycle.
module tb_mac_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic [4:0] qf = '0;
  logic       abort = 1'b0;
  logic       src_valid = 1'b0;
  logic       sink_ready = 1'b0;

  logic       o_src_ready, o_pipe_valid, o_pipe_inhibit, o_res_last, o_busy, o_done;
  logic [4:0] o_Q_frac;
  logic [4:1] pipe;
  logic       res_valid;

  int n_cmp = 0;
  int n_mis = 0;

  // job-level reference model
  bit         m_active, m_done_pend;
  int         m_len, m_issued, m_retired;
  logic [4:0] m_qf;

  // observed per-job tallies
  int t_iss, t_ret, t_last, t_last_idx, t_done, t_inh, t_stall;
  int cyc, last_iss_cyc, done_cyc;
  int src_pct, sink_pct;

  mac_seq_ctrl #(.CNT_W(8), .Q_W(5)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_len          (len),
    .i_Q_frac       (qf),
    .i_abort        (abort),
    .i_src_valid    (src_valid),
    .o_src_ready    (o_src_ready),
    .o_pipe_valid   (o_pipe_valid),
    .o_pipe_inhibit (o_pipe_inhibit),
    .i_res_valid    (res_valid),
    .i_sink_ready   (sink_ready),
    .o_res_last     (o_res_last),
    .o_Q_frac       (o_Q_frac),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  // Four MAC stages of valid bits, frozen while the stage-4 result is back-pressured.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else if (!(pipe[4] && !sink_ready)) pipe <= {pipe[3:1], o_pipe_valid};
  end
  assign res_valid = pipe[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    m_active = 0; m_done_pend = 0; m_len = 0; m_issued = 0; m_retired = 0; m_qf = '0;
  endtask

  task automatic clear_tally();
    t_iss = 0; t_ret = 0; t_last = 0; t_last_idx = 0; t_done = 0; t_inh = 0; t_stall = 0;
    last_iss_cyc = 0; done_cyc = 0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
  task automatic step();
    logic e_inh, e_val, e_last;
    bit   e_ret;
    @(negedge clk);
    e_inh  = res_valid & ~sink_ready;
    e_val  = m_active & (m_issued < m_len) & src_valid & ~e_inh & ~abort;
    e_ret  = m_active & res_valid & sink_ready;
    e_last = m_active & res_valid & (m_retired == m_len - 1);
    check("inhibit",    32'(o_pipe_inhibit), 32'(e_inh));
    check("pipe_valid", 32'(o_pipe_valid),   32'(e_val));
    check("src_ready",  32'(o_src_ready),    32'(e_val));
    check("res_last",   32'(o_res_last),     32'(e_last));
    check("busy",       32'(o_busy),         32'(m_active | m_done_pend));
    check("done",       32'(o_done),         32'(m_done_pend));
    check("q_frac",     32'(o_Q_frac),       32'(m_qf));

    if (o_pipe_valid) begin
      t_iss++; last_iss_cyc = cyc; t_stall = 0;
    end else if (e_inh) begin
      t_stall++;
    end
    if (e_inh) t_inh++;
    if (res_valid && sink_ready && m_active) begin
      t_ret++;
      if (o_res_last) begin t_last++; t_last_idx = t_ret; end
    end
    if (o_done) begin t_done++; done_cyc = cyc; end

    if (m_done_pend) begin
      m_done_pend = 0;
    end else if (m_active) begin
      if (abort) begin
        m_active = 0; m_issued = 0; m_retired = 0;
      end else begin
        m_issued  += int'(e_val);
        m_retired += int'(e_ret);
        if (m_retired == m_len) begin m_active = 0; m_done_pend = 1; end
      end
    end else if (start && len != 0 && !abort) begin
      m_active = 1; m_len = int'(len); m_qf = qf; m_issued = 0; m_retired = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    src_valid  = ($urandom_range(99) < src_pct);
    sink_ready = ($urandom_range(99) < sink_pct);
    step();
  endtask

  task automatic begin_job(input int n, input logic [4:0] q);
    clear_tally();
    start = 1'b1; len = 8'(n); qf = q;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int k = 0;
    while (t_done == 0 && k < budget) begin cycle(); k++; end
    check("job_done_count", t_done, 1);
    check("job_issues", t_iss, n);
    check("job_retires", t_ret, n);
    check("job_last_count", t_last, 1);
    check("job_last_index", t_last_idx, n);
    check("done_latency", done_cyc - last_iss_cyc, 5 + t_stall);
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(o_pipe_valid),   0);
    check({tag, "_ready"},   32'(o_src_ready),    0);
    check({tag, "_inhibit"}, 32'(o_pipe_inhibit), 0);
    check({tag, "_last"},    32'(o_res_last),     0);
    check({tag, "_busy"},    32'(o_busy),         0);
    check({tag, "_done"},    32'(o_done),         0);
    check({tag, "_qfrac"},   32'(o_Q_frac),       0);
    check({tag, "_state"},   32'(dut.state_q),    0);
    check({tag, "_icnt"},    32'(dut.issue_cnt_q), 0);
    check({tag, "_rcnt"},    32'(dut.ret_cnt_q),  0);
    check({tag, "_len"},     32'(dut.len_q),      0);
  endtask

  initial begin
    int k;
    logic [4:0] pat;
    clear_model(); clear_tally(); cyc = 0;
    src_pct = 100; sink_pct = 100;

    // power-on reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    step();

    // basic job, no stalls
    src_valid = 1; sink_ready = 1;
    begin_job(4, 5'd7);
    wait_done(4, 50);

    // back-pressure on result 2
    begin_job(6, 5'd12);
    k = 0;
    while (!(t_ret == 1 && res_valid) && k < 50) begin step(); k++; end
    check("bp_setup", t_ret, 1);
    sink_ready = 0;
    repeat (3) step();
    check("bp_held_retires", t_ret, 1);
    sink_ready = 1;
    wait_done(6, 50);
    check("bp_inhibit_cycles", t_inh, 3);

    // source starvation 1,0,1,0,1
    src_valid = 0;
    begin_job(3, 5'd2);
    pat = 5'b10101;
    for (int i = 0; i < 5; i++) begin src_valid = pat[i]; step(); end
    check("starve_issues", t_iss, 3);
    src_pct = 0; sink_pct = 100;
    wait_done(3, 50);

    // zero-length start is ignored
    clear_tally();
    start = 1; len = 8'd0; qf = 5'd9;
    step();
    start = 0;
    repeat (3) step();
    check("len0_done", t_done, 0);
    check("len0_busy", 32'(o_busy), 0);

    // maximum length with a second start while busy
    src_pct = 80; sink_pct = 80;
    begin_job(255, 5'd19);
    repeat (10) cycle();
    start = 1; len = 8'd9; qf = 5'd3;
    cycle();
    start = 0;
    wait_done(255, 3000);

    // abort in DRAIN with two results outstanding
    src_valid = 1; sink_ready = 1; src_pct = 100; sink_pct = 100;
    begin_job(4, 5'd21);
    k = 0;
    while (!(t_iss == 4 && t_ret == 2) && k < 50) begin step(); k++; end
    check("abort_setup", t_ret, 2);
    t_done = 0; t_last = 0;
    abort = 1;
    step();
    abort = 0;
    repeat (4) step();
    check("abort_no_done", t_done, 0);
    check("abort_no_last", t_last, 0);
    check("abort_icnt", 32'(dut.issue_cnt_q), 0);
    check("abort_rcnt", 32'(dut.ret_cnt_q), 0);

    // async reset mid-RUN, then a fresh job
    begin_job(10, 5'd14);
    k = 0;
    while (t_iss < 3 && k < 50) begin step(); k++; end
    check("rst_setup", t_iss, 3);
    rst_n = 0;
    #1;
    check_reset_outputs("midrst");
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1;
    begin_job(2, 5'd5);
    wait_done(2, 50);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      src_pct  = $urandom_range(100, 30);
      sink_pct = $urandom_range(100, 30);
      k = $urandom_range(20, 1);
      begin_job(k, 5'($urandom));
      wait_done(k, 1000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
